// File: rtl/pulse_frame_synth_if.sv
// BRAM port bundle between the pulse frame synthesiser and its frame buffer.
interface pulse_frame_synth_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 11
);
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   // The synthesiser drives the BRAM port; the memory returns read data.
   modport master (
      output mem_en,
      output mem_we,
      output mem_addr,
      output mem_wdata,
      input  mem_rdata
   );

   modport slave (
      input  mem_en,
      input  mem_we,
      input  mem_addr,
      input  mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/pulse_frame_synth.sv
// Neutron-pulse frame synthesiser: zero-fills a frame held in an external
// single-port BRAM, then superimposes cps copies of a programmable pulse shape
// at LFSR-chosen offsets using read-modify-write with saturating addition.
module pulse_frame_synth #(
   parameter int          DATA_W    = 16,
   parameter int          SHAPE_LEN = 50,
   parameter int          ADDR_W    = 11,
   parameter int          CPS_W     = 16,
   parameter logic [15:0] LFSR_SEED = 16'hACE1,
   localparam int         SA_W      = (SHAPE_LEN > 1) ? $clog2(SHAPE_LEN) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [CPS_W-1:0]    cps,
   input  logic                shape_we,
   input  logic [SA_W-1:0]     shape_addr,
   input  logic [DATA_W-1:0]   shape_data,
   pulse_frame_synth_if.master mem,
   output logic                busy,
   output logic                done,
   output logic [CPS_W-1:0]    pulse_cnt,
   output logic                sat_seen
);

   localparam logic [SA_W-1:0] K_LAST = SA_W'(SHAPE_LEN - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_PICK,
      S_RD,
      S_WR,
      S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   clr_q, clr_d;
   logic [ADDR_W-1:0]   off_q, off_d;
   logic [SA_W-1:0]     k_q, k_d;
   logic [15:0]         lfsr_q, lfsr_d;
   logic [CPS_W-1:0]    cps_q, cps_d;
   logic [CPS_W-1:0]    pcnt_q, pcnt_d;
   logic                sat_q, sat_d;
   logic                en_q, en_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   logic [DATA_W-1:0]   shape_q [SHAPE_LEN];
   logic                shape_wr;
   logic [DATA_W:0]     sum_w;

   // One extra bit holds the carry so saturation can be detected.
   function automatic logic [DATA_W:0] add_wide(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
      return {1'b0, a} + {1'b0, b};
   endfunction

   // Clamp a widened sum to the largest representable sample.
   function automatic logic [DATA_W-1:0] sat_clip(input logic [DATA_W:0] s);
      return s[DATA_W] ? {DATA_W{1'b1}} : s[DATA_W-1:0];
   endfunction

   // 16-bit Fibonacci LFSR, taps 16/14/13/11.
   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
   endfunction

   // The RMW sum uses the word read in the preceding RD cycle, so write data
   // is a combinational function of mem_rdata during WR.
   assign sum_w         = add_wide(mem.mem_rdata, shape_q[k_q]);
   assign mem.mem_wdata = (state_q == S_WR) ? sat_clip(sum_w) : '0;
   assign mem.mem_en    = en_q;
   assign mem.mem_we    = we_q;
   assign mem.mem_addr  = addr_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign pulse_cnt     = pcnt_q;
   assign sat_seen      = sat_q;

   // Shape writes only land while no frame is being built.
   always_comb begin
      shape_wr = shape_we && ((state_q == S_IDLE) || (state_q == S_DONE)) &&
                 (32'(shape_addr) < 32'(SHAPE_LEN));
   end

   // Shape table: plain storage, deliberately not reset.
   always_ff @(posedge clk) begin
      if (shape_wr) shape_q[shape_addr] <= shape_data;
   end

   // Next-state, counters and registered BRAM/handshake outputs.
   always_comb begin
      state_d = state_q;
      clr_d   = clr_q;
      off_d   = off_q;
      k_d     = k_q;
      lfsr_d  = lfsr_q;
      cps_d   = cps_q;
      pcnt_d  = pcnt_q;
      sat_d   = sat_q;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               cps_d   = cps;
               pcnt_d  = '0;
               sat_d   = 1'b0;
               clr_d   = '0;
               state_d = S_CLEAR;
            end
         end
         S_CLEAR: begin
            if (clr_q == {ADDR_W{1'b1}}) begin
               state_d = (cps_q != '0) ? S_PICK : S_DONE;
            end else begin
               clr_d = clr_q + ADDR_W'(1);
            end
         end
         S_PICK: begin
            off_d   = lfsr_q[ADDR_W-1:0];
            lfsr_d  = lfsr_step(lfsr_q);
            k_d     = '0;
            state_d = S_RD;
         end
         S_RD: begin
            state_d = S_WR;
         end
         S_WR: begin
            if (sum_w[DATA_W]) sat_d = 1'b1;
            if (k_q != K_LAST) begin
               k_d     = k_q + SA_W'(1);
               state_d = S_RD;
            end else begin
               pcnt_d  = pcnt_q + CPS_W'(1);
               state_d = (pcnt_d == cps_q) ? S_DONE : S_PICK;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Outputs are decoded from the state being entered so they are
      // registered and line up with that state's cycle.
      en_d   = (state_d == S_CLEAR) || (state_d == S_RD) || (state_d == S_WR);
      we_d   = (state_d == S_CLEAR) || (state_d == S_WR);
      addr_d = (state_d == S_CLEAR) ? clr_d : (off_d + ADDR_W'(k_d));
      busy_d = (state_d == S_CLEAR) || (state_d == S_PICK) ||
               (state_d == S_RD)    || (state_d == S_WR);
      done_d = (state_d == S_DONE);
   end

   // Frame FSM and its registered outputs; reset aborts any frame in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         clr_q   <= '0;
         off_q   <= '0;
         k_q     <= '0;
         lfsr_q  <= LFSR_SEED;
         cps_q   <= '0;
         pcnt_q  <= '0;
         sat_q   <= 1'b0;
         en_q    <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         clr_q   <= clr_d;
         off_q   <= off_d;
         k_q     <= k_d;
         lfsr_q  <= lfsr_d;
         cps_q   <= cps_d;
         pcnt_q  <= pcnt_d;
         sat_q   <= sat_d;
         en_q    <= en_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

endmodule

// File: tb/tb_pulse_frame_synth.sv
// Scoreboard bench for pulse_frame_synth: three instances with different LFSR
// seeds run in lockstep against a behavioural frame model.
module tb_pulse_frame_synth;

   localparam int DATA_W    = 8;
   localparam int SHAPE_LEN = 4;
   localparam int ADDR_W    = 4;
   localparam int CPS_W     = 16;
   localparam int NI        = 3;
   localparam int FRAME_LEN = 1 << ADDR_W;
   localparam int SA_W      = 2;
   localparam int MAXV      = (1 << DATA_W) - 1;
   localparam logic [15:0] SEEDS [NI] = '{16'hACE1, 16'h000E, 16'h0001};

   typedef struct packed {
      logic [NI-1:0][FRAME_LEN-1:0][DATA_W-1:0] frame;
      logic [NI-1:0]                            sat;
      logic [CPS_W-1:0]                         pcnt;
      logic [31:0]                              done_cyc;
      logic [31:0]                              busy_len;
      logic [31:0]                              wr_cnt;
   } exp_t;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                start = 1'b0;
   logic [CPS_W-1:0]    cps = '0;
   logic                shape_we = 1'b0;
   logic [SA_W-1:0]     shape_addr = '0;
   logic [DATA_W-1:0]   shape_data = '0;
   logic                scramble = 1'b0;

   logic                en_a    [NI];
   logic                we_a    [NI];
   logic [ADDR_W-1:0]   addr_a  [NI];
   logic [DATA_W-1:0]   wdata_a [NI];
   logic [DATA_W-1:0]   rdata_a [NI];
   logic                busy_a  [NI];
   logic                done_a  [NI];
   logic                sat_a   [NI];
   logic [CPS_W-1:0]    pcnt_a  [NI];
   logic [DATA_W-1:0]   bram    [NI][FRAME_LEN];

   logic [15:0]         lfsr_m  [NI];
   logic [DATA_W-1:0]   shape_m [SHAPE_LEN];
   exp_t                exp_q   [$];

   int cyc = 0;
   int checks = 0;
   int failures = 0;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      pulse_frame_synth_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();
      pulse_frame_synth #(
         .DATA_W(DATA_W), .SHAPE_LEN(SHAPE_LEN), .ADDR_W(ADDR_W),
         .CPS_W(CPS_W), .LFSR_SEED(SEEDS[g])
      ) dut (
         .clk(clk), .rst_n(rst_n), .start(start), .cps(cps),
         .shape_we(shape_we), .shape_addr(shape_addr), .shape_data(shape_data),
         .mem(bus), .busy(busy_a[g]), .done(done_a[g]),
         .pulse_cnt(pcnt_a[g]), .sat_seen(sat_a[g])
      );
      assign en_a[g]        = bus.mem_en;
      assign we_a[g]        = bus.mem_we;
      assign addr_a[g]      = bus.mem_addr;
      assign wdata_a[g]     = bus.mem_wdata;
      assign bus.mem_rdata  = rdata_a[g];
   end

   initial forever #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Single-port BRAM models, 1-cycle read latency; scramble fills with junk.
   always @(posedge clk) begin
      for (int g = 0; g < NI; g++) begin
         if (scramble) begin
            for (int a = 0; a < FRAME_LEN; a++) bram[g][a] <= DATA_W'($urandom_range(1, MAXV));
         end else if (en_a[g]) begin
            if (we_a[g]) bram[g][addr_a[g]] <= wdata_a[g];
            else         rdata_a[g] <= bram[g][addr_a[g]];
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Behavioural frame: zero, then add each pulse word-by-word with clamping.
   task automatic predict(input logic [CPS_W-1:0] n, input int c0, output exp_t e);
      int fr [FRAME_LEN];
      int off, idx, acc;
      e = '0;
      for (int g = 0; g < NI; g++) begin
         for (int a = 0; a < FRAME_LEN; a++) fr[a] = 0;
         for (int p = 0; p < int'(n); p++) begin
            off = int'(lfsr_m[g]) % FRAME_LEN;
            lfsr_m[g] = {lfsr_m[g][14:0], lfsr_m[g][15] ^ lfsr_m[g][13] ^ lfsr_m[g][12] ^ lfsr_m[g][10]};
            for (int k = 0; k < SHAPE_LEN; k++) begin
               idx = (off + k) % FRAME_LEN;
               acc = fr[idx] + int'(shape_m[k]);
               if (acc > MAXV) begin
                  acc = MAXV;
                  e.sat[g] = 1'b1;
               end
               fr[idx] = acc;
            end
         end
         for (int a = 0; a < FRAME_LEN; a++) e.frame[g][a] = DATA_W'(fr[a]);
      end
      e.pcnt     = n;
      e.done_cyc = 32'(c0 + FRAME_LEN + int'(n) * (1 + 2 * SHAPE_LEN) + 1);
      e.busy_len = 32'(FRAME_LEN + int'(n) * (1 + 2 * SHAPE_LEN));
      e.wr_cnt   = 32'(FRAME_LEN + int'(n) * SHAPE_LEN);
   endtask

   // Monitor: pops the expected frame whenever a done pulse appears.
   initial begin : monitor
      exp_t e;
      int   busy_run, wr_run, bad;
      busy_run = 0;
      wr_run   = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            busy_run = 0;
            wr_run   = 0;
         end else begin
            if (busy_a[0]) busy_run++;
            if (en_a[0] && we_a[0]) wr_run++;
            if (done_a[0]) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_done", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  chk("done_cycle", 64'(cyc), 64'(e.done_cyc));
                  chk("busy_len", 64'(busy_run), 64'(e.busy_len));
                  chk("write_count", 64'(wr_run), 64'(e.wr_cnt));
                  chk("busy_in_done", 64'(busy_a[0]), 0);
                  chk("en_in_done", 64'(en_a[0]), 0);
                  for (int g = 0; g < NI; g++) begin
                     if (g > 0) chk("done_lockstep", 64'(done_a[g]), 1);
                     chk("pulse_cnt", 64'(pcnt_a[g]), 64'(e.pcnt));
                     chk("sat_seen", 64'(sat_a[g]), 64'(e.sat[g]));
                     bad = -1;
                     for (int a = 0; a < FRAME_LEN; a++)
                        if (bad < 0 && bram[g][a] !== e.frame[g][a]) bad = a;
                     checks++;
                     if (bad >= 0) begin
                        failures++;
                        $display("FAIL frame inst %0d addr %0d: got %0d expected %0d",
                                 g, bad, bram[g][bad], e.frame[g][bad]);
                     end
                  end
               end
               busy_run = 0;
               wr_run   = 0;
            end
         end
      end
   end

   task automatic write_word(input int k, input int v);
      shape_we   = 1'b1;
      shape_addr = SA_W'(k);
      shape_data = DATA_W'(v);
      shape_m[k] = DATA_W'(v);
      @(negedge clk);
      shape_we   = 1'b0;
   endtask

   task automatic set_shape(input int a, input int b, input int c, input int d);
      write_word(0, a);
      write_word(1, b);
      write_word(2, c);
      write_word(3, d);
   endtask

   task automatic reset_dut();
      rst_n = 1'b0;
      exp_q.delete();
      for (int g = 0; g < NI; g++) lfsr_m[g] = SEEDS[g];
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // Issue one frame; optionally inject ignored start/shape/cps noise and
   // optionally abort it with reset in relative cycle abort_at.
   task automatic do_frame(input logic [CPS_W-1:0] n, input bit noise, input int abort_at);
      exp_t e;
      bit   seen;
      int   bad;
      predict(n, cyc, e);
      exp_q.push_back(e);
      start = 1'b1;
      cps   = n;
      seen  = 1'b0;
      for (int t = 1; t < 300 && !seen; t++) begin
         @(negedge clk);
         start    = 1'b0;
         shape_we = 1'b0;
         if (abort_at > 0 && t == abort_at) begin
            chk("busy_before_abort", 64'(busy_a[0]), 1);
            #2 rst_n = 1'b0;
            #1;
            bad = 0;
            for (int g = 0; g < NI; g++)
               if (en_a[g] !== 1'b0 || we_a[g] !== 1'b0 || busy_a[g] !== 1'b0 ||
                   done_a[g] !== 1'b0 || pcnt_a[g] !== '0 || sat_a[g] !== 1'b0 ||
                   wdata_a[g] !== '0) bad++;
            chk("abort_outputs_zero", 64'(bad), 0);
            exp_q.delete();
            for (int g = 0; g < NI; g++) lfsr_m[g] = SEEDS[g];
            @(negedge clk);
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            return;
         end
         if (done_a[0]) begin
            seen = 1'b1;
         end else if (noise) begin
            start      = 1'($urandom_range(0, 1));
            cps        = CPS_W'($urandom);
            shape_we   = 1'($urandom_range(0, 1));
            shape_addr = SA_W'($urandom);
            shape_data = DATA_W'($urandom);
         end
      end
      if (!seen) chk("frame_timeout", 0, 1);
      @(negedge clk);
      chk("done_one_cycle", 64'(done_a[0]), 0);
   endtask

   task automatic chk_frame(input string name, input int g, input int ef [FRAME_LEN]);
      int bad;
      bad = -1;
      for (int a = 0; a < FRAME_LEN; a++)
         if (bad < 0 && int'(bram[g][a]) != ef[a]) bad = a;
      checks++;
      if (bad >= 0) begin
         failures++;
         $display("FAIL %s addr %0d: got %0d expected %0d", name, bad, bram[g][bad], ef[bad]);
      end
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got time limit expected finish");
      $fatal(1, "simulation time limit");
   end

   initial begin : stimulus
      int ef3 [FRAME_LEN];
      int ef4 [FRAME_LEN];
      int ef5 [FRAME_LEN];
      int idle_bad;

      for (int a = 0; a < FRAME_LEN; a++) begin
         ef3[a] = 0;
         ef4[a] = 0;
         ef5[a] = 0;
      end
      ef3[1] = 10;  ef3[2] = 20;  ef3[3] = 30;  ef3[4] = 40;
      ef4[14] = 10; ef4[15] = 20; ef4[0] = 30;  ef4[1] = 40;
      ef5[1] = 200; ef5[2] = 255; ef5[3] = 255; ef5[4] = 255; ef5[5] = 200;
      for (int g = 0; g < NI; g++) lfsr_m[g] = SEEDS[g];
      for (int k = 0; k < SHAPE_LEN; k++) shape_m[k] = '0;

      // Reset and idle: everything quiet, no BRAM activity.
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_busy", 64'(busy_a[0]), 0);
      chk("reset_en", 64'(en_a[0]), 0);
      rst_n = 1'b1;
      idle_bad = 0;
      repeat (5) begin
         @(negedge clk);
         for (int g = 0; g < NI; g++)
            if (en_a[g] !== 1'b0 || we_a[g] !== 1'b0 || busy_a[g] !== 1'b0 ||
                done_a[g] !== 1'b0 || pcnt_a[g] !== '0 || sat_a[g] !== 1'b0 ||
                wdata_a[g] !== '0) idle_bad++;
      end
      chk("idle_outputs_zero", 64'(idle_bad), 0);

      // cps=0 over a junk-filled buffer: pure clear.
      scramble = 1'b1;
      @(negedge clk);
      scramble = 1'b0;
      do_frame(0, 1'b0, 0);

      // Single pulse: plain placement (seed ACE1) and wrap (seed 000E).
      set_shape(10, 20, 30, 40);
      do_frame(1, 1'b0, 0);
      chk_frame("scn3_frame", 0, ef3);
      chk_frame("scn4_wrap_frame", 1, ef4);

      // Two overlapping saturating pulses from seed 0001.
      reset_dut();
      set_shape(200, 200, 200, 200);
      do_frame(2, 1'b0, 0);
      chk_frame("scn5_frame", 2, ef5);
      chk("scn5_sat", 64'(sat_a[2]), 1);
      chk("scn5_pcnt", 64'(pcnt_a[2]), 2);

      // Random shapes and pulse counts with ignored mid-frame noise.
      for (int i = 0; i < 6; i++) begin
         for (int k = 0; k < SHAPE_LEN; k++) write_word(k, int'($urandom_range(0, MAXV)));
         do_frame(CPS_W'($urandom_range(0, 4)), 1'b1, 0);
      end

      // Abort mid-frame, then the fresh-seed result must repeat.
      do_frame(3, 1'b1, 20);
      set_shape(10, 20, 30, 40);
      do_frame(1, 1'b0, 0);
      chk_frame("post_abort_frame", 0, ef3);

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", 64'(exp_q.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pulse_frame_synth.md
# pulse_frame_synth

Parametrised neutron-pulse frame synthesiser. On each start it zero-fills a frame buffer held in an external single-port BRAM, then superimposes `cps` copies of a programmable pulse-shape table at LFSR-chosen offsets using read-modify-write with saturating fixed-point addition. It replaces the single-shot fp32 pulse loader in the pulse path: it is generalised in sample width, shape length and frame depth, and adds wrap-around placement, overflow saturation and a start/busy/done handshake.

## Interface
- `DATA_W`, 16, sample width (unsigned fixed point)
- `SHAPE_LEN`, 50, pulse-shape samples, ≥1
- `ADDR_W`, 11, frame address width; FRAME_LEN = 2**ADDR_W; ADDR_W ≤ 16
- `CPS_W`, 16, width of pulse-count input
- `LFSR_SEED`, 16'hACE1, LFSR reset value, must be nonzero
- Clocking and reset (already decided): one clock; reset is asynchronous and active-low.
- `clk` in 1 — sole clock, rising edge
- `rst_n` in 1 — asynchronous active-low reset
- `start` in 1 — one-cycle request; sampled only in IDLE
- `cps` in CPS_W — pulses per frame, latched on accepted start
- `shape_we` in 1 — shape table write strobe; ignored while busy
- `shape_addr` in clog2(SHAPE_LEN) — shape index; writes with index ≥ SHAPE_LEN are ignored
- `shape_data` in DATA_W — shape sample
- `mem_en` out 1 — BRAM enable
- `mem_we` out 1 — BRAM write enable
- `mem_addr` out ADDR_W — BRAM word address
- `mem_wdata` out DATA_W — BRAM write data
- `mem_rdata` in DATA_W — BRAM read data, valid one cycle after the address is presented with en=1, we=0
- `busy` out 1 — frame in progress
- `done` out 1 — one-cycle completion pulse
- `pulse_cnt` out CPS_W — pulses fully added in the current frame
- `sat_seen` out 1 — sticky; set when any add saturated; cleared on accepted start

## Operation
- Reset: all outputs 0; FSM to IDLE; LFSR = LFSR_SEED. The shape table is not reset (initial contents are zero).
- LFSR: 16-bit Fibonacci, `lfsr <= {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}`. It advances only in PICK and persists across frames.
- FSM states: IDLE, CLEAR, PICK, RD, WR, DONE.
- IDLE: on `start`=1, latch cps, clear pulse_cnt and sat_seen, set busy, go to CLEAR with address counter 0.
- CLEAR: en=1, we=1, wdata=0, addr=counter. Runs for FRAME_LEN cycles (addr 0..FRAME_LEN-1). Then go to PICK if latched cps>0, else DONE.
- PICK: offset <= lfsr[ADDR_W-1:0] (pre-advance value); LFSR advances; k <= 0; en=0; go to RD.
- RD: en=1, we=0, addr = (offset + k) mod FRAME_LEN (ADDR_W-bit truncating add); go to WR.
- WR: en=1, we=1, same addr, wdata = min(mem_rdata + shape[k], 2**DATA_W−1), computed at DATA_W+1 bits. Set sat_seen if the carry bit is 1.
  - If k < SHAPE_LEN−1: k+1, go to RD.
  - Otherwise: pulse_cnt+1. If pulse_cnt+1 == cps go to DONE, else go to PICK.
- DONE: en=0, we=0, busy=0, done=1 for one cycle; go to IDLE. pulse_cnt and sat_seen hold until the next accepted start.
- start while busy: ignored, with no effect on cps, counters or LFSR.
- cps changes mid-frame: no effect; the latched value is used.
- Overlapping pulses and wrapped pulses accumulate via read-modify-write. Same-address hazards cannot occur because each RD/WR pair completes before the next RD.
- Shape writes in IDLE/DONE take effect on the next frame.
- rst_n low mid-frame: immediate abort, outputs 0, IDLE, LFSR reseeded. BRAM contents are left partial.

## Timing
- start sampled at edge 0. CLEAR occupies cycles 1..FRAME_LEN.
- Each pulse takes 1 + 2·SHAPE_LEN cycles.
- done high in cycle FRAME_LEN + cps·(1+2·SHAPE_LEN) + 1.
- busy high from cycle 1 through the cycle before done.
- mem_en and mem_we are low in IDLE, PICK and DONE.
- Earliest restart: start sampled in the cycle after done.

## Test plan
Bench configuration: ADDR_W=4, SHAPE_LEN=4, DATA_W=8. BRAM model has 1-cycle read latency.
- Reset, then idle 5 cycles -> all outputs 0; no BRAM writes.
- cps=0, start -> 16 zero writes to addr 0..15; done in cycle 17; pulse_cnt=0.
- SEED=16'hACE1, shape {10,20,30,40}, cps=1 -> offset 1; frame[1..4]={10,20,30,40}, all other words 0; done in cycle 26; pulse_cnt=1.
- SEED=16'h000E, same shape, cps=1 -> wrap: frame[14]=10, [15]=20, [0]=30, [1]=40.
- SEED=16'h0001, shape {200,200,200,200}, cps=2 -> offsets 1, 2:
  - frame[1]=200, [2..4]=255, [5]=200
  - sat_seen=1; done in cycle 35
- Robustness:
  - start pulses and shape_we during busy are ignored; the frame result is unchanged.
  - rst_n dropped at cycle 20 -> outputs 0 immediately.
  - the next start with SEED=16'hACE1 reproduces the scenario-3 result.
